// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
// Build option: UART_ARB_TIMEOUT_EN (see uart_tx_arbiter).
package uart_arb_pkg;

  typedef enum logic {
    StIdle,
    StLock
  } arb_state_e;

  localparam int unsigned UART_ARB_MAX_REQ = 8;
  localparam int unsigned IdleCntW = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after last_gnt_i,
// searching upward with wrap-around.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  last_gnt_i,
  output logic [ID_W-1:0]  pick_id_o,
  output logic             pick_any_o
);

  logic [ID_W:0] idx;

  always_comb begin
    pick_id_o  = '0;
    pick_any_o = 1'b0;
    idx        = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      // One extra bit so last_gnt + k never overflows before the wrap.
      idx = {1'b0, last_gnt_i} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(N_REQ)) begin
        idx = idx - (ID_W + 1)'(N_REQ);
      end
      if (!pick_any_o && valid_i[idx[ID_W-1:0]]) begin
        pick_id_o  = idx[ID_W-1:0];
        pick_any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter in front of the UART TX write port.
// Define UART_ARB_TIMEOUT_EN to enable forced release after TIMEOUT idle cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*8-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         uart_data_o,
  output logic               uart_tx_en_o,
  input  logic               uart_full_i,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               busy_o,
  output logic               timeout_pulse_o
);

  localparam logic [IdleCntW-1:0] TimeoutLim = IdleCntW'(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] last_gnt_q, last_gnt_d;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic            xfer;
  logic            timeout_hit;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .valid_i    (req_valid_i),
    .last_gnt_i (last_gnt_q),
    .pick_id_o  (pick_id),
    .pick_any_o (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_gnt_d   = last_gnt_q;
    xfer         = 1'b0;
    req_ready_o  = '0;
    uart_tx_en_o = 1'b0;
    uart_data_o  = 8'h00;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_id;
          state_d = StLock;
        end
      end
      StLock: begin
        xfer                 = req_valid_i[grant_q] & ~uart_full_i;
        uart_tx_en_o         = xfer;
        req_ready_o[grant_q] = xfer;
        uart_data_o          = req_data_i[8*grant_q +: 8];
        if (xfer && req_last_i[grant_q]) begin
          last_gnt_d = grant_q;
          state_d    = StIdle;
        end else if (timeout_hit) begin
          last_gnt_d = grant_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_gnt_q <= ID_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_gnt_q <= last_gnt_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [IdleCntW-1:0] idle_cnt_q, idle_cnt_d;

  // Counts grantee-idle cycles; the TIMEOUT-th consecutive one forces release.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (state_q == StLock && !req_valid_i[grant_q]) begin
      if (idle_cnt_q == TimeoutLim - IdleCntW'(1)) begin
        timeout_hit = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IdleCntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign timeout_pulse_o = timeout_hit;
`else
  logic unused_timeout_lim;
  assign unused_timeout_lim = ^TimeoutLim;
  assign timeout_hit        = 1'b0;
  assign timeout_pulse_o    = 1'b0;
`endif

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q == StLock);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus scoreboarded requester model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic           clk = 1'b0;
  logic           RSTn;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic [7:0]     uart_data;
  logic           uart_tx_en, uart_full, busy, timeout_pulse;
  logic [IW-1:0]  grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .ID_W    (IW),
    .TIMEOUT (10)
  ) dut (
    .clk             (clk),
    .RSTn            (RSTn),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .uart_data_o     (uart_data),
    .uart_tx_en_o    (uart_tx_en),
    .uart_full_i     (uart_full),
    .grant_id_o      (grant_id),
    .busy_o          (busy),
    .timeout_pulse_o (timeout_pulse)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [7:0]   data;
    logic [N-1:0] last;
    logic         full;
    logic         en;
    logic [7:0]   odata;
    logic         busy;
    logic [N-1:0] ready;
  } vec_t;

  function automatic vec_t mk(logic [N-1:0] v, logic [7:0] d, logic [N-1:0] l, logic f,
                              logic en, logic [7:0] od, logic b, logic [N-1:0] r);
    vec_t t;
    t.valid = v; t.data = d; t.last = l; t.full = f;
    t.en = en; t.odata = od; t.busy = b; t.ready = r;
    return t;
  endfunction

  // Requester model: per-requester byte queues {last, data} and expected-byte scoreboard.
  logic [8:0]    rq   [N][$];
  logic [7:0]    expq [N][$];
  logic [IW-1:0] gseq [$];
  int            tx_count [N];
  int            cyc, last_tx_cyc, pulse_cyc, pulse_count;
  logic          prev_busy;
  logic [IW-1:0] owner;

  task automatic push_msg(input int r, input logic [7:0] base, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      rq[r].push_back({(with_last && k == len - 1), base + 8'(k)});
      expq[r].push_back(base + 8'(k));
    end
  endtask

  task automatic drive_model();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic reset_stats();
    cyc = 0; last_tx_cyc = -1; pulse_cyc = -1; pulse_count = 0; prev_busy = 1'b0;
    gseq.delete();
    for (int i = 0; i < N; i++) tx_count[i] = 0;
  endtask

  // One cycle: sample outputs on the falling edge, retire accepted bytes after the rising edge.
  task automatic step();
    logic [N-1:0] acc;
    int g;
    @(negedge clk);
    acc = req_ready;
    g   = int'(grant_id);
    if (busy && !prev_busy) begin
      gseq.push_back(grant_id);
      owner = grant_id;
    end
    prev_busy = busy;
    if (timeout_pulse) begin
      if (pulse_cyc < 0) pulse_cyc = cyc;
      pulse_count++;
    end
    if (uart_tx_en) begin
      check("ready_onehot", 32'(req_ready), 32'(1) << g);
      check("no_interleave", 32'(grant_id), 32'(owner));
      if (expq[g].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h from req %0d, expected none", uart_data, g);
      end else begin
        check("uart_data", 32'(uart_data), 32'(expq[g].pop_front()));
      end
      tx_count[g]++;
      last_tx_cyc = cyc;
    end else if (req_ready != '0) begin
      check("ready_without_tx", 32'(req_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
    drive_model();
    cyc++;
  endtask

  task automatic run_until_empty(input int budget);
    for (int n = 0; n < budget && !model_empty(); n++) step();
    check("drain_in_budget", 32'(model_empty()), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_tx_en"}, 32'(uart_tx_en), 32'(0));
    check({tag, "_ready"}, 32'(req_ready), 32'(0));
    check({tag, "_data"}, 32'(uart_data), 32'(0));
    check({tag, "_grant"}, 32'(grant_id), 32'(0));
    check({tag, "_pulse"}, 32'(timeout_pulse), 32'(0));
  endtask

  vec_t vecs [15];

  initial begin
    vecs[0]  = mk(4'h1, 8'h41, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
    vecs[1]  = mk(4'h1, 8'h41, 4'h0, 1'b0, 1'b1, 8'h41, 1'b1, 4'h1);
    vecs[2]  = mk(4'h1, 8'h42, 4'h0, 1'b0, 1'b1, 8'h42, 1'b1, 4'h1);
    vecs[3]  = mk(4'h1, 8'h43, 4'h1, 1'b0, 1'b1, 8'h43, 1'b1, 4'h1);
    vecs[4]  = mk(4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
    vecs[5]  = mk(4'h1, 8'h50, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
    vecs[6]  = mk(4'h1, 8'h50, 4'h0, 1'b0, 1'b1, 8'h50, 1'b1, 4'h1);
    for (int i = 7; i <= 11; i++) vecs[i] = mk(4'h1, 8'h51, 4'h0, 1'b1, 1'b0, 8'h51, 1'b1, 4'h0);
    vecs[12] = mk(4'h1, 8'h51, 4'h0, 1'b0, 1'b1, 8'h51, 1'b1, 4'h1);
    vecs[13] = mk(4'h1, 8'h52, 4'h1, 1'b0, 1'b1, 8'h52, 1'b1, 4'h1);
    vecs[14] = mk(4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);

    RSTn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; uart_full = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    RSTn = 1'b1;

    // 3-byte message from req0, then a message with a 5-cycle uart_full stall.
    for (int i = 0; i < 15; i++) begin
      req_valid = vecs[i].valid;
      req_data  = {24'h0, vecs[i].data};
      req_last  = vecs[i].last;
      uart_full = vecs[i].full;
      @(negedge clk);
      check($sformatf("vec%0d_tx_en", i), 32'(uart_tx_en), 32'(vecs[i].en));
      check($sformatf("vec%0d_data", i), 32'(uart_data), 32'(vecs[i].odata));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(0));
      check($sformatf("vec%0d_pulse", i), 32'(timeout_pulse), 32'(0));
      @(posedge clk);
      #1;
    end
    uart_full = 1'b0;

    // req1 and req2 both backlogged with two 2-byte messages each.
    reset_stats();
    push_msg(1, 8'h11, 2, 1'b1); push_msg(1, 8'h13, 2, 1'b1);
    push_msg(2, 8'h21, 2, 1'b1); push_msg(2, 8'h23, 2, 1'b1);
    drive_model();
    run_until_empty(40);
    check("rr_grant_count", 32'(gseq.size()), 32'(4));
    if (gseq.size() >= 4) begin
      check("rr_grant0", 32'(gseq[0]), 32'(1));
      check("rr_grant1", 32'(gseq[1]), 32'(2));
      check("rr_grant2", 32'(gseq[2]), 32'(1));
      check("rr_grant3", 32'(gseq[3]), 32'(2));
    end
    check("rr_turnaround_cycle", 32'(last_tx_cyc), 32'(11));

    // req3 sends one byte without last and goes quiet; req0 waits behind it.
    reset_stats();
    push_msg(3, 8'h33, 1, 1'b0);
    push_msg(0, 8'h0A, 1, 1'b1);
    drive_model();
`ifdef UART_ARB_TIMEOUT_EN
    for (int n = 0; n < 16; n++) step();
    check("to_pulse_cycle", 32'(pulse_cyc), 32'(11));
    check("to_pulse_count", 32'(pulse_count), 32'(1));
    check("to_req0_bytes", 32'(tx_count[0]), 32'(1));
    check("to_req0_cycle", 32'(last_tx_cyc), 32'(13));
    check("to_grant_count", 32'(gseq.size()), 32'(2));
    if (gseq.size() >= 2) begin
      check("to_grant0", 32'(gseq[0]), 32'(3));
      check("to_grant1", 32'(gseq[1]), 32'(0));
    end
`else
    for (int n = 0; n < 110; n++) step();
    check("hold_busy", 32'(busy), 32'(1));
    check("hold_grant", 32'(grant_id), 32'(3));
    check("hold_req3_bytes", 32'(tx_count[3]), 32'(1));
    check("hold_req0_starved", 32'(tx_count[0]), 32'(0));
    check("hold_grant_count", 32'(gseq.size()), 32'(1));
    check("hold_no_pulse", 32'(pulse_count), 32'(0));
`endif

    // Clean slate, then reset during the second byte of a 4-byte message from req2.
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      expq[i].delete();
    end
    drive_model();
    RSTn = 1'b0;
    @(posedge clk);
    #1;
    RSTn = 1'b1;
    reset_stats();
    push_msg(2, 8'h70, 4, 1'b1);
    drive_model();
    step();
    step();
    #1;
    check("mid_msg_tx_en", 32'(uart_tx_en), 32'(1));
    check("mid_msg_data", 32'(uart_data), 32'(8'h71));
    check("mid_msg_grant", 32'(grant_id), 32'(2));
    RSTn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check("rst_held_busy", 32'(busy), 32'(0));
    RSTn = 1'b1;
    reset_stats();
    push_msg(0, 8'h0B, 1, 1'b1);
    drive_model();
    run_until_empty(40);
    check("post_rst_grant_count", 32'(gseq.size()), 32'(2));
    if (gseq.size() >= 2) begin
      check("post_rst_grant0", 32'(gseq[0]), 32'(0));
      check("post_rst_grant1", 32'(gseq[1]), 32'(2));
    end
    check("post_rst_req2_bytes", 32'(tx_count[2]), 32'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
